// File: rtl/and_sweep_checker.sv
// Exhaustive sweep driver for an attached and_cascade: walks every N-bit vector,
// samples dut_y after SETTLE extra cycles and tallies mismatches against the golden AND.
module and_sweep_checker #(
    parameter int unsigned N      = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N-1:0] dut_in,
    input  logic         dut_y,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail_vec,
    output logic         first_fail_valid
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [N-1:0] VecMax   = {N{1'b1}};
    localparam logic [N:0]   ErrMax   = {1'b1, {N{1'b0}}};
    localparam logic [3:0]   SettleW  = 4'(SETTLE);

    state_e       state;
    logic [N-1:0] vec;
    logic [3:0]   dwell;
    logic         sample;
    logic         mismatch;

    assign sample   = (dwell == SettleW);
    assign mismatch = (dut_y != (vec == VecMax));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            vec              <= '0;
            dwell            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            dut_in           <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state            <= StRun;
                        busy             <= 1'b1;
                        vec              <= '0;
                        dwell            <= '0;
                        dut_in           <= '0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                StRun: begin
                    if (sample) begin
                        if (mismatch) begin
                            if (err_count != ErrMax) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (vec == VecMax) begin
                            state  <= StDone;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            dut_in <= '0;
                            // err_count has not absorbed the final sample yet
                            pass   <= (err_count == '0) && !mismatch;
                        end else begin
                            vec    <= vec + 1'b1;
                            dut_in <= vec + 1'b1;
                            dwell  <= '0;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_sweep_checker.sv
// Bench for and_sweep_checker: table of DUT fault models, random fault masks scored by an
// independent sweep model, and hand sequences for ignored starts, back-to-back and reset.
module tb_and_sweep_checker;

    localparam int unsigned N      = 8;
    localparam int unsigned SETTLE = 1;
    localparam int unsigned NVEC   = 1 << N;
    localparam int unsigned LAT    = 1 + NVEC * (SETTLE + 1);
    localparam int unsigned PERIOD = NVEC * (SETTLE + 1) + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, pass, dut_y, first_fail_valid;
    logic [N-1:0]   dut_in, first_fail_vec;
    logic [N:0]     err_count;

    int             mode = 0;
    logic [NVEC-1:0] fault_mask = '0;

    int total = 0;
    int bad   = 0;

    and_sweep_checker #(.N(N), .SETTLE(SETTLE)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .dut_in           (dut_in),
        .dut_y            (dut_y),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    // Models of the attached and_cascade, healthy or broken
    always_comb begin
        dut_y = 1'b0;
        case (mode)
            0: dut_y = &dut_in;
            1: dut_y = 1'b0;
            2: dut_y = 1'b1;
            3: dut_y = dut_in[0];
            4: dut_y = (&dut_in) ^ fault_mask[dut_in];
            default: dut_y = &dut_in;
        endcase
    end

    typedef struct {
        int   mode;
        int   err;
        int   ffv;
        bit   valid;
        bit   pass;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Starts a sweep from a negedge; optionally re-pulses start at run cycle extra_at.
    // Returns the run cycle (1 = first cycle after the accepting edge) at which done was seen.
    task automatic run_sweep(input int extra_at, output int cycles, output bit seq_ok);
        int m;
        seq_ok = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 1;
        while (!done && m < 3 * LAT) begin
            if (busy !== 1'b1 || dut_in !== N'((m - 1) / (SETTLE + 1))) seq_ok = 1'b0;
            start = (m == extra_at);
            @(negedge clk);
            m++;
        end
        start = 1'b0;
        cycles = m;
        if (busy !== 1'b0 || dut_in !== '0) seq_ok = 1'b0;
    endtask

    task automatic expect_results(input string tag, input int err, input int ffv,
                                  input bit valid, input bit pass_exp);
        check({tag, ".err_count"}, 32'(err_count), 32'(err));
        check({tag, ".first_fail_vec"}, 32'(first_fail_vec), 32'(ffv));
        check({tag, ".first_fail_valid"}, 32'(first_fail_valid), 32'(valid));
        check({tag, ".pass"}, 32'(pass), 32'(pass_exp));
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, ".rst_outs"},
              {busy, done, pass, first_fail_valid, 32'(dut_in), 32'(err_count),
               32'(first_fail_vec)} == '0 ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        vec_t tbl[5];
        int   cycles;
        bit   seq_ok;
        int   dones;
        int   n;
        int   m_err, m_ffv;
        bit   m_valid;

        tbl[0] = '{mode: 0, err: 0,   ffv: 0,    valid: 1'b0, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 1,   ffv: 'hFF, valid: 1'b1, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 255, ffv: 'h00, valid: 1'b1, pass: 1'b0};
        tbl[3] = '{mode: 3, err: 127, ffv: 'h01, valid: 1'b1, pass: 1'b0};
        tbl[4] = '{mode: 0, err: 0,   ffv: 0,    valid: 1'b0, pass: 1'b1};

        #12;
        expect_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_reset_values("post_reset_idle");

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            run_sweep(-1, cycles, seq_ok);
            check($sformatf("tbl%0d.latency", i), 32'(cycles), 32'(LAT));
            check($sformatf("tbl%0d.dut_in_seq", i), 32'(seq_ok), 32'd1);
            expect_results($sformatf("tbl%0d", i), tbl[i].err, tbl[i].ffv, tbl[i].valid,
                           tbl[i].pass);
            @(negedge clk);
            check($sformatf("tbl%0d.held_idle", i), {busy, done, 30'(err_count)},
                  {2'b00, 30'(tbl[i].err)});
        end

        // Random faulty cascades scored by a straightforward sweep model
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < NVEC; v++) fault_mask[v] = ($urandom_range(0, 15) == 0);
            if (r == 3) fault_mask = '0;
            mode = 4;
            m_err = 0; m_ffv = 0; m_valid = 1'b0;
            for (int v = 0; v < NVEC; v++) begin
                bit golden, got;
                golden = (v == NVEC - 1);
                got    = golden ^ fault_mask[v];
                if (got != golden) begin
                    m_err++;
                    if (!m_valid) begin
                        m_ffv = v;
                        m_valid = 1'b1;
                    end
                end
            end
            run_sweep(-1, cycles, seq_ok);
            check($sformatf("rand%0d.latency", r), 32'(cycles), 32'(LAT));
            expect_results($sformatf("rand%0d", r), m_err, m_ffv, m_valid, m_err == 0);
            @(negedge clk);
        end

        // start pulses mid-run and in the DONE cycle must be ignored
        mode = 0;
        run_sweep(50, cycles, seq_ok);
        check("ignore.latency", 32'(cycles), 32'(LAT));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        check("ignore.no_extra_sweep", 32'(dones), 32'd0);

        // start held high: back-to-back sweeps
        start = 1'b1;
        n = 0;
        while (!done && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        @(negedge clk);
        n++;
        while (!done && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("held.period", 32'(n), 32'(PERIOD));
        check("held.pass", 32'(pass), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("held.idle_after", 32'(busy), 32'd0);

        // Reset mid-sweep aborts without a done pulse
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_reset_values("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        check("abort.no_done", 32'(dones), 32'd0);
        expect_reset_values("abort_idle");
        mode = 0;
        run_sweep(-1, cycles, seq_ok);
        check("after_abort.latency", 32'(cycles), 32'(LAT));
        check("after_abort.dut_in_seq", 32'(seq_ok), 32'd1);
        expect_results("after_abort", 0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
